// File: rtl/adc_avg_filter_if.sv
// Sample/result bundle between the XADC wrapper side and the averaging filter.
// The filter attaches through the slave modport; the producer/observer side uses master.
interface adc_avg_filter_if;
  logic [15:0] data_i;
  logic        eoc_i;
  logic        clear_i;
  logic [11:0] avg_o;
  logic        avg_valid_o;
  logic [11:0] min_o;
  logic [11:0] max_o;
  logic        alarm_o;

  modport master (
    output data_i, eoc_i, clear_i,
    input  avg_o, avg_valid_o, min_o, max_o, alarm_o
  );

  modport slave (
    input  data_i, eoc_i, clear_i,
    output avg_o, avg_valid_o, min_o, max_o, alarm_o
  );
endinterface

// File: rtl/adc_avg_filter.sv
// Windowed average/min/max of 12-bit XADC samples, published once per 2^LOG2_N samples,
// with a hysteresis alarm evaluated on each new average.
module adc_avg_filter #(
  parameter int unsigned LOG2_N    = 4,
  parameter logic [11:0] THRESH_HI = 12'hC00,
  parameter logic [11:0] THRESH_LO = 12'h800
) (
  input  logic            clk_i,
  input  logic            reset_i,
  adc_avg_filter_if.slave bus
);

  localparam int unsigned ACC_W = 12 + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_PUB = 1'b1
  } st_e;

  st_e               st_q, st_d;
  logic              eoc_q, eoc_d;
  logic              s_vld_q, s_vld_d;
  logic [11:0]       s_data_q, s_data_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [11:0]       win_min_q, win_min_d;
  logic [11:0]       win_max_q, win_max_d;
  logic [ACC_W-1:0]  fin_sum_q, fin_sum_d;
  logic [11:0]       fin_min_q, fin_min_d;
  logic [11:0]       fin_max_q, fin_max_d;
  logic [11:0]       avg_q, avg_d;
  logic [11:0]       min_q, min_d;
  logic [11:0]       max_q, max_d;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;

  logic              capture_s;
  logic              win_end_s;
  logic              pub_s;
  logic [ACC_W-1:0]  sum_s;
  logic [11:0]       min_s;
  logic [11:0]       max_s;
  logic [11:0]       new_avg_s;

  assign capture_s = bus.eoc_i & ~eoc_q;
  assign sum_s     = acc_q + ACC_W'(s_data_q);
  assign min_s     = (s_data_q < win_min_q) ? s_data_q : win_min_q;
  assign max_s     = (s_data_q > win_max_q) ? s_data_q : win_max_q;
  assign win_end_s = s_vld_q & (cnt_q == CNT_LAST);
  assign pub_s     = (st_q == ST_PUB) & ~bus.clear_i;
  assign new_avg_s = fin_sum_q[LOG2_N+11:LOG2_N];

  // FSM next state: one PUB cycle follows every completed (non-cleared) window.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_ACC: begin
        if (win_end_s && !bus.clear_i) begin
          st_d = ST_PUB;
        end else begin
          st_d = ST_ACC;
        end
      end
      ST_PUB:  st_d = ST_ACC;
      default: st_d = ST_ACC;
    endcase
  end

  // Datapath next state for capture, accumulate and publish stages.
  always_comb begin
    eoc_d       = bus.eoc_i;
    s_vld_d     = 1'b0;
    s_data_d    = s_data_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_min_d   = win_min_q;
    win_max_d   = win_max_q;
    fin_sum_d   = fin_sum_q;
    fin_min_d   = fin_min_q;
    fin_max_d   = fin_max_q;
    avg_d       = avg_q;
    min_d       = min_q;
    max_d       = max_q;
    avg_valid_d = pub_s;
    alarm_d     = alarm_q;

    if (capture_s) begin
      s_data_d = bus.data_i[15:4];
    end else begin
      s_data_d = s_data_q;
    end

    if (bus.clear_i) begin
      s_vld_d   = 1'b0;
      acc_d     = '0;
      cnt_d     = '0;
      win_min_d = 12'hFFF;
      win_max_d = 12'h000;
    end else if (s_vld_q) begin
      s_vld_d = capture_s;
      cnt_d   = cnt_q + CNT_ONE;
      if (win_end_s) begin
        fin_sum_d = sum_s;
        fin_min_d = min_s;
        fin_max_d = max_s;
        acc_d     = '0;
        win_min_d = 12'hFFF;
        win_max_d = 12'h000;
      end else begin
        acc_d     = sum_s;
        win_min_d = min_s;
        win_max_d = max_s;
      end
    end else begin
      s_vld_d = capture_s;
    end

    // Hysteresis: between the two thresholds the previous alarm level is kept.
    if (pub_s) begin
      avg_d = new_avg_s;
      min_d = fin_min_q;
      max_d = fin_max_q;
      if (new_avg_s >= THRESH_HI) begin
        alarm_d = 1'b1;
      end else if (new_avg_s < THRESH_LO) begin
        alarm_d = 1'b0;
      end else begin
        alarm_d = alarm_q;
      end
    end else begin
      alarm_d = alarm_q;
    end
  end

  // State registers; eoc_q resets high so a strobe already high at release is ignored.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q        <= ST_ACC;
      eoc_q       <= 1'b1;
      s_vld_q     <= 1'b0;
      s_data_q    <= 12'h000;
      acc_q       <= '0;
      cnt_q       <= '0;
      win_min_q   <= 12'hFFF;
      win_max_q   <= 12'h000;
      fin_sum_q   <= '0;
      fin_min_q   <= 12'h000;
      fin_max_q   <= 12'h000;
      avg_q       <= 12'h000;
      min_q       <= 12'h000;
      max_q       <= 12'h000;
      avg_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      eoc_q       <= eoc_d;
      s_vld_q     <= s_vld_d;
      s_data_q    <= s_data_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      win_min_q   <= win_min_d;
      win_max_q   <= win_max_d;
      fin_sum_q   <= fin_sum_d;
      fin_min_q   <= fin_min_d;
      fin_max_q   <= fin_max_d;
      avg_q       <= avg_d;
      min_q       <= min_d;
      max_q       <= max_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus.avg_o       = avg_q;
  assign bus.min_o       = min_q;
  assign bus.max_o       = max_q;
  assign bus.avg_valid_o = avg_valid_q;
  assign bus.alarm_o     = alarm_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed + randomized bench for adc_avg_filter against a queue-based window model.
module tb_adc_avg_filter;
  localparam int          LOG2_N = 4;
  localparam int          N      = 16;
  localparam logic [11:0] HI     = 12'hC00;
  localparam logic [11:0] LO     = 12'h800;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_avg_filter_if bus ();

  adc_avg_filter #(.LOG2_N(LOG2_N), .THRESH_HI(HI), .THRESH_LO(LO)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Output monitor: counts pulses, back-to-back pulses and changes without a pulse.
  int          pulses_seen = 0;
  int          unstable    = 0;
  int          back2back   = 0;
  logic [11:0] p_avg = 12'h000, p_min = 12'h000, p_max = 12'h000;
  logic        p_alarm = 1'b0, p_valid = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.avg_valid_o === 1'b1) pulses_seen = pulses_seen + 1;
      if (bus.avg_valid_o === 1'b1 && p_valid === 1'b1) back2back = back2back + 1;
      if (bus.avg_valid_o !== 1'b1 && (bus.avg_o !== p_avg || bus.min_o !== p_min ||
          bus.max_o !== p_max || bus.alarm_o !== p_alarm)) unstable = unstable + 1;
    end
    p_avg   = bus.avg_o;
    p_min   = bus.min_o;
    p_max   = bus.max_o;
    p_alarm = bus.alarm_o;
    p_valid = bus.avg_valid_o;
  end

  // Reference model: samples collected per window, statistics computed when full.
  int          win[$];
  logic [11:0] m_avg = 12'h000, m_min = 12'h000, m_max = 12'h000;
  logic        m_alarm = 1'b0;
  int          m_pulses = 0;
  int          base = 0;

  function automatic void model_sample(input logic [15:0] d);
    int s, lo_v, hi_v;
    win.push_back(int'(d[15:4]));
    if (win.size() == N) begin
      s = 0; lo_v = 4095; hi_v = 0;
      foreach (win[i]) begin
        s = s + win[i];
        if (win[i] < lo_v) lo_v = win[i];
        if (win[i] > hi_v) hi_v = win[i];
      end
      m_avg = 12'(s / N);
      m_min = 12'(lo_v);
      m_max = 12'(hi_v);
      if (m_avg >= HI) m_alarm = 1'b1;
      else if (m_avg < LO) m_alarm = 1'b0;
      m_pulses = m_pulses + 1;
      win.delete();
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input int hi, input int lo);
    bus.data_i = d;
    bus.eoc_i  = 1'b1;
    repeat (hi) @(negedge clk);
    bus.eoc_i = 1'b0;
    repeat (lo) @(negedge clk);
    model_sample(d);
  endtask

  task automatic check_window(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_pulses"}, 32'(pulses_seen - base), 32'(m_pulses));
    base     = pulses_seen;
    m_pulses = 0;
    chk({tag, "_avg"},   32'(bus.avg_o),   32'(m_avg));
    chk({tag, "_min"},   32'(bus.min_o),   32'(m_min));
    chk({tag, "_max"},   32'(bus.max_o),   32'(m_max));
    chk({tag, "_alarm"}, 32'(bus.alarm_o), 32'(m_alarm));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_avg"},   32'(bus.avg_o),       32'h0);
    chk({tag, "_min"},   32'(bus.min_o),       32'h0);
    chk({tag, "_max"},   32'(bus.max_o),       32'h0);
    chk({tag, "_valid"}, 32'(bus.avg_valid_o), 32'h0);
    chk({tag, "_alarm"}, 32'(bus.alarm_o),     32'h0);
  endtask

  logic [11:0] hyst_v[4] = '{12'hC00, 12'h900, 12'h7FF, 12'hBFF};
  logic        hyst_a[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    bus.data_i  = 16'h0000;
    bus.eoc_i   = 1'b1;
    bus.clear_i = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");
    // eoc_i high across reset release must not count as a sample
    repeat (3) @(negedge clk);
    bus.eoc_i = 1'b0;
    @(negedge clk);
    base = pulses_seen;

    // Constant input with exact latency on the 16th sample
    for (int i = 0; i < N - 1; i++) send(16'h8000, 1, 1);
    bus.data_i = 16'h8000;
    bus.eoc_i  = 1'b1;
    @(negedge clk);
    chk("lat_k", 32'(bus.avg_valid_o), 32'h0);
    bus.eoc_i = 1'b0;
    @(negedge clk);
    chk("lat_k1", 32'(bus.avg_valid_o), 32'h0);
    @(negedge clk);
    chk("lat_k2", 32'(bus.avg_valid_o), 32'h1);
    @(negedge clk);
    chk("lat_k3", 32'(bus.avg_valid_o), 32'h0);
    model_sample(16'h8000);
    check_window("const");
    chk("const_fixed_avg", 32'(bus.avg_o), 32'h800);

    // Ramp then full scale
    for (int i = 0; i < N; i++) send(16'(i << 4), 1, 1);
    check_window("ramp");
    chk("ramp_fixed_avg", 32'(bus.avg_o), 32'h7);
    chk("ramp_fixed_max", 32'(bus.max_o), 32'hF);
    for (int i = 0; i < N; i++) send(16'hFFF0, 1, 1);
    check_window("full");
    chk("full_fixed_avg", 32'(bus.avg_o), 32'hFFF);

    // Hysteresis sequence
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < N; i++) send({hyst_v[w], 4'h0}, 1, 1);
      check_window("hyst");
      chk("hyst_fixed_alarm", 32'(bus.alarm_o), 32'(hyst_a[w]));
    end

    // Long strobe: one sample per conversion regardless of strobe length
    for (int i = 0; i < N; i++) send(16'($urandom), 50, 2);
    check_window("long");

    // Clear mid-window: outputs hold, window restarts
    for (int i = 0; i < 10; i++) send(16'h0000, 1, 1);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    win.delete();
    check_window("clr_hold");
    for (int i = 0; i < N; i++) send(16'h1000, 1, 1);
    check_window("clr_new");
    chk("clr_fixed_avg", 32'(bus.avg_o), 32'h100);

    // Clear coincident with the 16th capture
    for (int i = 0; i < N - 1; i++) send(16'($urandom), 1, 1);
    bus.data_i  = 16'($urandom);
    bus.eoc_i   = 1'b1;
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    bus.eoc_i   = 1'b0;
    @(negedge clk);
    win.delete();
    check_window("clr_cap");

    // Clear coincident with the window-end accumulate
    for (int i = 0; i < N - 1; i++) send(16'($urandom), 1, 1);
    bus.data_i = 16'($urandom);
    bus.eoc_i  = 1'b1;
    @(negedge clk);
    bus.eoc_i   = 1'b0;
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    win.delete();
    check_window("clr_end");

    // Randomized windows with random strobe timing
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < N; i++)
        send(16'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      check_window("rand");
    end

    // Reset mid-window discards everything
    for (int i = 0; i < 8; i++) send(16'($urandom), 1, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    win.delete();
    m_avg = 12'h000; m_min = 12'h000; m_max = 12'h000; m_alarm = 1'b0; m_pulses = 0;
    @(negedge clk);
    check_zero("rst_mid");
    base = pulses_seen;
    for (int i = 0; i < N; i++) send(16'($urandom), 1, 1);
    check_window("rst_new");

    chk("stable_between_pulses", 32'(unstable), 32'h0);
    chk("no_back_to_back", 32'(back2back), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

Downstream consumer of the XADC wrapper (`ADC`). It captures each 16-bit conversion result on the end-of-conversion strobe and accumulates a fixed power-of-two window of 12-bit samples. At each window end it publishes the window average, minimum and maximum. A hysteresis alarm on the average is also evaluated there. It runs in the wrapper's output clock domain (`clk_o` of `ADC` drives `clk_i`) and is wired directly to `data_o`/`eoc_o`.

## Interface
- `LOG2_N`, 4: log2 of window length; N = 2^LOG2_N samples, legal 1..8
- `THRESH_HI`, 12'hC00: alarm set level, compared against the average
- `THRESH_LO`, 12'h800: alarm clear level; must be ≤ `THRESH_HI`

- `clk_i`  in  1  block clock, single domain
- `reset_i`  in  1  synchronous, active-high reset
- `data_i`  in  16  XADC result; sample = `data_i[15:4]`, bits [3:0] ignored
- `eoc_i`  in  1  end-of-conversion from `ADC`; a rising edge marks a new sample
- `clear_i`  in  1  synchronous window restart
- `avg_o`  out  12  last window average
- `avg_valid_o`  out  1  one-cycle pulse when `avg_o`/`min_o`/`max_o`/`alarm_o` update
- `min_o`  out  12  last window minimum
- `max_o`  out  12  last window maximum
- `alarm_o`  out  1  hysteresis alarm level

## Operation
- **Edge detect.**
  - `eoc_q` <= `eoc_i`; capture when `eoc_i && !eoc_q`.
  - `eoc_q` resets to 1, so `eoc_i` high at reset release is not a sample.
  - `eoc_i` held high for many cycles yields exactly one sample.
- **Stage S1 (capture).** On capture: `s_data` <= `data_i[15:4]`, `s_vld` <= 1. Otherwise `s_vld` <= 0.
- **Stage S2 (accumulate).** When `s_vld`:
  - `acc` += `s_data`.
  - `win_min`/`win_max` update with `s_data`.
  - `cnt` increments.
- **Accumulator width.** `acc` is 12+LOG2_N bits, zero-extended add, so it never overflows.
- **Window end.**
  - Window end is the S2 update that takes `cnt` from N-1 to 0 (wrap).
  - That update latches `fin_sum` = `acc`+`s_data`, the final min/max, and sets `pub` <= 1.
  - In the same cycle it resets `acc` to 0, `win_min` to 12'hFFF and `win_max` to 12'h000.
- **Stage S3 (publish).** When `pub`:
  - `avg_o` <= `fin_sum[LOG2_N+11:LOG2_N]` (truncating shift, no rounding).
  - `min_o`/`max_o` <= latched values.
  - `avg_valid_o` <= 1.
- **Alarm.**
  - Evaluated in S3 on the new average.
  - If the new average is ≥ `THRESH_HI`, `alarm_o` <= 1.
  - Else if it is < `THRESH_LO`, `alarm_o` <= 0.
  - Else `alarm_o` holds.
- **FSM `st`.** ACC ↔ PUB.
  - ACC → PUB on window end.
  - PUB → ACC unconditionally after one cycle.
  - A sample arriving in S2 while in PUB is accumulated into the new window; no sample is lost.
- **`clear_i`.**
  - Zeroes `cnt` and `acc`, resets `win_min`/`win_max`, and drops `s_vld` and `pub`.
  - Published outputs and `alarm_o` hold.
  - `clear_i` coincident with a capture drops that sample.
  - `clear_i` coincident with a window-end S2 update cancels the publish.
- **`reset_i`.** Mid-window, reset discards everything, including a pending publish.

## Timing
- **Reset values.**
  - All outputs 0: `avg_o`, `min_o`, `max_o`, `avg_valid_o`, `alarm_o`.
  - Internal state: `cnt` 0, `acc` 0, `win_min` FFF, `win_max` 000, `st` ACC, `eoc_q` 1.
- **Latency.**
  - Rising edge of `eoc_i` first sampled high at clock edge k; `s_vld` is high after edge k.
  - The accumulate happens at edge k+1.
  - For the Nth sample, `avg_valid_o` is high for exactly the one cycle after edge k+2.
- **Throughput.** One sample per 2 cycles (the minimum `eoc_i` edge spacing).
- **Idle state.** `avg_valid_o` is never high on two consecutive cycles at the XADC conversion rate; outputs are stable between pulses.

## Test plan
- **Constant input.** LOG2_N=4, 16 `eoc_i` pulses with `data_i`=16'h8000 → one `avg_valid_o` pulse 2 cycles after the 16th S1 capture. Expected `avg_o`=12'h800, `min_o`=`max_o`=12'h800, `alarm_o`=0.
- **Ramp and full scale.**
  - Samples 0..15 (`data_i`=n<<4) → `avg_o`=7 (120/16), `min_o`=0, `max_o`=15.
  - Then 16× 16'hFFF0 → `avg_o`=12'hFFF, with no accumulator wrap.
- **Hysteresis.**
  - Window averages C00 → `alarm_o`=1.
  - Then 900 → still 1.
  - Then 7FF → 0.
  - Then BFF → 0.
- **Long strobe.** `eoc_i` held high 50 cycles per conversion, 16 conversions → exactly one window. Also, `eoc_i` high at reset release → not counted.
- **Clear mid-window.**
  - 10 samples of 0, `clear_i`, then 16 samples of 0x100 → `avg_o`=0x100; previous outputs held until that pulse.
  - `clear_i` on the 16th sample's capture cycle → no pulse.
- **Reset mid-window.** `reset_i` after 8 samples → all outputs 0; the next 16 samples produce a correct independent average.
